// File: rtl/blake_block_sched.sv
// rtl/blake_block_sched.sv - per-message block sequencer for the BLAKE-512 compression core
//
// Accepts message blocks on a valid/ready handshake, keeps the 128-bit bit
// counter t, and steps the G-function datapath through init-v load, the
// column/diagonal round steps and chaining-value finalization.
//
// Ports:
//   clk, rstb        clock (rising edge), asynchronous active-low reset
//   abort            synchronous abandon of the current message
//   msg_valid/ready  block handshake; msg_last and msg_bits sampled on accept
//   init_hv          pulse: load IV into h (accept cycle of a message's first block)
//   load_v           pulse: load v from h, salt, constants and t_out
//   step_en, phase   G-step enable; phase 0 = column, 1 = diagonal
//   round_idx        current round; sigma_idx = round_idx mod 10
//   final_en         pulse: h <= h ^ s ^ v_lo ^ v_hi
//   t_out            counter value for the block in flight
//   busy             sequencer not idle
//   digest_valid     pulse: h holds the final digest
module blake_block_sched #(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = 128,
    parameter int BITS_W     = 11
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              abort,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic              msg_last,
    input  logic [BITS_W-1:0] msg_bits,
    output logic              init_hv,
    output logic              load_v,
    output logic              step_en,
    output logic              phase,
    output logic [3:0]        round_idx,
    output logic [3:0]        sigma_idx,
    output logic              final_en,
    output logic [CNT_W-1:0]  t_out,
    output logic              busy,
    output logic              digest_valid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t             state_q, state_d;
    logic               first_blk_q, first_blk_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   t_acc_q, t_acc_d;
    logic [CNT_W-1:0]   t_out_q, t_out_d;
    logic [3:0]         round_q, round_d;
    logic [3:0]         sigma_q, sigma_d;
    logic               phase_q, phase_d;

    logic               accept;
    logic [CNT_W-1:0]   t_sum;

    assign msg_ready    = (state_q == IDLE) && !abort;
    assign accept       = msg_valid && msg_ready;
    assign init_hv      = accept && first_blk_q;
    assign load_v       = (state_q == LOAD);
    assign step_en      = (state_q == ROUND);
    assign final_en     = (state_q == FINAL);
    assign digest_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign phase        = phase_q;
    assign round_idx    = round_q;
    assign sigma_idx    = sigma_q;
    assign t_out        = t_out_q;

    // Modular add; overflow past 2^CNT_W is dropped on purpose.
    assign t_sum = t_acc_q + CNT_W'(msg_bits);

    always_comb begin
        state_d     = state_q;
        first_blk_d = first_blk_q;
        last_d      = last_q;
        t_acc_d     = t_acc_q;
        t_out_d     = t_out_q;
        round_d     = round_q;
        sigma_d     = sigma_q;
        phase_d     = phase_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    t_acc_d = t_sum;
                    // A padding-only block is compressed with t=0.
                    t_out_d = (msg_bits == '0) ? '0 : t_sum;
                    last_d  = msg_last;
                    round_d = 4'd0;
                    sigma_d = 4'd0;
                    phase_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                round_d = 4'd0;
                sigma_d = 4'd0;
                phase_d = 1'b0;
                state_d = ROUND;
            end
            ROUND: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (round_q == LAST_ROUND) begin
                        // Indices hold on the last round for downstream debug visibility.
                        state_d = FINAL;
                    end else begin
                        round_d = round_q + 4'd1;
                        sigma_d = (sigma_q == 4'd9) ? 4'd0 : sigma_q + 4'd1;
                    end
                end
            end
            FINAL: begin
                if (last_q) begin
                    state_d     = DONE;
                    first_blk_d = 1'b1;
                    t_acc_d     = '0;
                end else begin
                    state_d     = IDLE;
                    first_blk_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything and discards the message context.
        if (abort) begin
            state_d     = IDLE;
            first_blk_d = 1'b1;
            t_acc_d     = '0;
            round_d     = 4'd0;
            sigma_d     = 4'd0;
            phase_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            first_blk_q <= 1'b1;
            last_q      <= 1'b0;
            t_acc_q     <= '0;
            t_out_q     <= '0;
            round_q     <= 4'd0;
            sigma_q     <= 4'd0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_blk_q <= first_blk_d;
            last_q      <= last_d;
            t_acc_q     <= t_acc_d;
            t_out_q     <= t_out_d;
            round_q     <= round_d;
            sigma_q     <= sigma_d;
            phase_q     <= phase_d;
        end
    end

    a_msg_bits_legal: assert property (@(posedge clk) disable iff (!rstb)
        accept |-> (msg_bits <= BITS_W'(1024)));

endmodule

// File: tb/tb_blake_block_sched.sv
// tb/tb_blake_block_sched.sv - directed self-checking bench for blake_block_sched
module tb_blake_block_sched;

    logic         clk = 1'b0;
    logic         rstb;
    logic         abort;
    logic         msg_valid;
    logic         msg_ready;
    logic         msg_last;
    logic [10:0]  msg_bits;
    logic         init_hv, load_v, step_en, phase, final_en, busy, digest_valid;
    logic [3:0]   round_idx, sigma_idx;
    logic [127:0] t_out;

    // Narrow-counter instance so counter wrap is reachable in a few blocks.
    logic         w_valid, w_ready, w_last;
    logic [10:0]  w_bits;
    logic         w_init_hv, w_load_v, w_step_en, w_phase, w_final_en, w_busy, w_digest_valid;
    logic [3:0]   w_round_idx, w_sigma_idx;
    logic [11:0]  w_t_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    blake_block_sched dut (
        .clk(clk), .rstb(rstb), .abort(abort),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_last(msg_last), .msg_bits(msg_bits),
        .init_hv(init_hv), .load_v(load_v), .step_en(step_en), .phase(phase),
        .round_idx(round_idx), .sigma_idx(sigma_idx), .final_en(final_en),
        .t_out(t_out), .busy(busy), .digest_valid(digest_valid)
    );

    blake_block_sched #(.NUM_ROUNDS(16), .CNT_W(12), .BITS_W(11)) dut_w (
        .clk(clk), .rstb(rstb), .abort(1'b0),
        .msg_valid(w_valid), .msg_ready(w_ready), .msg_last(w_last), .msg_bits(w_bits),
        .init_hv(w_init_hv), .load_v(w_load_v), .step_en(w_step_en), .phase(w_phase),
        .round_idx(w_round_idx), .sigma_idx(w_sigma_idx), .final_en(w_final_en),
        .t_out(w_t_out), .busy(w_busy), .digest_valid(w_digest_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block to completion, returning observed pulse counts.
    task automatic drive_block(input logic [10:0] bits, input logic last,
                               output int n_init, output logic [127:0] t_seen,
                               output int n_step, output int n_final,
                               output int n_dig, output int n_ready_busy);
        int guard;
        n_init = 0; n_step = 0; n_final = 0; n_dig = 0; n_ready_busy = 0;
        guard = 0;
        while (!msg_ready && guard < 100) begin tick(); guard++; end
        msg_valid = 1'b1; msg_bits = bits; msg_last = last;
        #1;
        if (init_hv) n_init++;
        tick();
        msg_valid = 1'b0; msg_last = 1'b0;
        t_seen = t_out;
        guard = 0;
        while (busy && guard < 60) begin
            if (step_en) n_step++;
            if (final_en) n_final++;
            if (digest_valid) n_dig++;
            if (msg_ready) n_ready_busy++;
            tick();
            guard++;
        end
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL block_timeout: busy=%0b after %0d cycles, required 0", busy, guard);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_last = 1'b0; msg_bits = '0;
        w_valid = 1'b0; w_last = 1'b0; w_bits = '0;
        #12;
        vectors++;
        if ({busy, load_v, step_en, final_en, digest_valid, init_hv, phase, round_idx, sigma_idx} !== 15'd0
            || t_out !== 128'd0 || msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: busy=%0b step=%0b round=%0d sigma=%0d t_out=%0d ready=%0b, required idle zeros ready=1",
                     busy, step_en, round_idx, sigma_idx, t_out, msg_ready);
        end
        tick();
        rstb = 1'b1;
        tick();
    endtask

    task automatic test_single_block();
        msg_valid = 1'b1; msg_last = 1'b1; msg_bits = 11'd1024;
        #1;
        vectors++;
        if (msg_ready !== 1'b1 || init_hv !== 1'b1 || load_v !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept: ready=%0b init_hv=%0b load_v=%0b, required 1 1 0", msg_ready, init_hv, load_v);
        end
        tick();
        msg_valid = 1'b0; msg_last = 1'b0;
        vectors++;
        if (load_v !== 1'b1 || step_en !== 1'b0 || busy !== 1'b1 || t_out !== 128'd1024 || msg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_load: load_v=%0b step=%0b busy=%0b t_out=%0d ready=%0b, required 1 0 1 1024 0",
                     load_v, step_en, busy, t_out, msg_ready);
        end
        for (int c = 0; c < 32; c++) begin
            tick();
            vectors++;
            if (step_en !== 1'b1 || phase !== c[0] || round_idx !== 4'(c / 2) || sigma_idx !== 4'((c / 2) % 10)) begin
                miscompares++;
                $display("FAIL single_round c=%0d: step=%0b phase=%0b round=%0d sigma=%0d, required 1 %0d %0d %0d",
                         c, step_en, phase, round_idx, sigma_idx, c % 2, c / 2, (c / 2) % 10);
            end
        end
        tick();
        vectors++;
        if (final_en !== 1'b1 || step_en !== 1'b0 || digest_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_final: final_en=%0b step=%0b digest=%0b, required 1 0 0", final_en, step_en, digest_valid);
        end
        tick();
        vectors++;
        if (digest_valid !== 1'b1 || final_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_digest: digest=%0b final_en=%0b busy=%0b, required 1 0 1", digest_valid, final_en, busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || digest_valid !== 1'b0 || msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_idle: busy=%0b digest=%0b ready=%0b, required 0 0 1", busy, digest_valid, msg_ready);
        end
    endtask

    task automatic test_two_blocks();
        int ni, ns, nf, nd, nrb;
        logic [127:0] ts;
        drive_block(11'd1024, 1'b0, ni, ts, ns, nf, nd, nrb);
        vectors++;
        if (ni != 1 || ts !== 128'd1024 || ns != 32 || nf != 1 || nd != 0 || nrb != 0) begin
            miscompares++;
            $display("FAIL two_blk1: init=%0d t=%0d steps=%0d final=%0d dig=%0d ready_busy=%0d, required 1 1024 32 1 0 0",
                     ni, ts, ns, nf, nd, nrb);
        end
        drive_block(11'd200, 1'b1, ni, ts, ns, nf, nd, nrb);
        vectors++;
        if (ni != 0 || ts !== 128'd1224 || ns != 32 || nf != 1 || nd != 1 || nrb != 0) begin
            miscompares++;
            $display("FAIL two_blk2: init=%0d t=%0d steps=%0d final=%0d dig=%0d ready_busy=%0d, required 0 1224 32 1 1 0",
                     ni, ts, ns, nf, nd, nrb);
        end
    endtask

    task automatic test_padding_block();
        int ni, ns, nf, nd, nrb;
        logic [127:0] ts;
        drive_block(11'd1024, 1'b0, ni, ts, ns, nf, nd, nrb);
        drive_block(11'd0, 1'b1, ni, ts, ns, nf, nd, nrb);
        vectors++;
        if (ni != 0 || ts !== 128'd0 || nd != 1) begin
            miscompares++;
            $display("FAIL pad_blk: init=%0d t=%0d dig=%0d, required 0 0 1", ni, ts, nd);
        end
        drive_block(11'd300, 1'b1, ni, ts, ns, nf, nd, nrb);
        vectors++;
        if (ni != 1 || ts !== 128'd300 || nd != 1) begin
            miscompares++;
            $display("FAIL pad_next_msg: init=%0d t=%0d dig=%0d, required 1 300 1", ni, ts, nd);
        end
    endtask

    task automatic test_abort();
        int guard, nf, nd, ni, ns, nrb;
        logic [127:0] ts;
        // Abort in IDLE alongside msg_valid must not accept.
        msg_valid = 1'b1; msg_bits = 11'd64; msg_last = 1'b1; abort = 1'b1;
        #1;
        vectors++;
        if (msg_ready !== 1'b0 || init_hv !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle_comb: ready=%0b init_hv=%0b, required 0 0", msg_ready, init_hv);
        end
        tick();
        abort = 1'b0; msg_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || load_v !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle_noaccept: busy=%0b load_v=%0b, required 0 0", busy, load_v);
        end
        // Abort mid-ROUND at round 7; prior block leaves first_blk clear.
        drive_block(11'd1024, 1'b0, ni, ts, ns, nf, nd, nrb);
        msg_valid = 1'b1; msg_bits = 11'd1024; msg_last = 1'b1;
        tick();
        msg_valid = 1'b0; msg_last = 1'b0;
        guard = 0;
        while (!(step_en && round_idx == 4'd7) && guard < 40) begin tick(); guard++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || step_en !== 1'b0 || round_idx !== 4'd0 || sigma_idx !== 4'd0 || phase !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_round: busy=%0b step=%0b round=%0d sigma=%0d phase=%0b, required 0 0 0 0 0",
                     busy, step_en, round_idx, sigma_idx, phase);
        end
        nf = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (final_en) nf++;
            if (digest_valid) nd++;
            tick();
        end
        vectors++;
        if (nf != 0 || nd != 0) begin
            miscompares++;
            $display("FAIL abort_no_pulses: final=%0d digest=%0d, required 0 0", nf, nd);
        end
        drive_block(11'd500, 1'b1, ni, ts, ns, nf, nd, nrb);
        vectors++;
        if (ni != 1 || ts !== 128'd500 || nd != 1) begin
            miscompares++;
            $display("FAIL abort_next_msg: init=%0d t=%0d dig=%0d, required 1 500 1", ni, ts, nd);
        end
    endtask

    task automatic test_reset_mid_round();
        int ni, ns, nf, nd, nrb;
        logic [127:0] ts;
        msg_valid = 1'b1; msg_bits = 11'd1024; msg_last = 1'b1;
        tick();
        msg_valid = 1'b0; msg_last = 1'b0;
        repeat (10) tick();
        #1;
        rstb = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || step_en !== 1'b0 || round_idx !== 4'd0 || sigma_idx !== 4'd0
            || t_out !== 128'd0 || msg_ready !== 1'b1 || final_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_round: busy=%0b step=%0b round=%0d sigma=%0d t_out=%0d ready=%0b, required 0 0 0 0 0 1",
                     busy, step_en, round_idx, sigma_idx, t_out, msg_ready);
        end
        tick();
        #2;
        rstb = 1'b1;
        tick();
        drive_block(11'd1024, 1'b1, ni, ts, ns, nf, nd, nrb);
        vectors++;
        if (ni != 1 || ts !== 128'd1024 || ns != 32 || nf != 1 || nd != 1) begin
            miscompares++;
            $display("FAIL reset_then_hash: init=%0d t=%0d steps=%0d final=%0d dig=%0d, required 1 1024 32 1 1",
                     ni, ts, ns, nf, nd);
        end
    endtask

    task automatic test_counter_wrap();
        // 12-bit counter: 4 x 999 = 3996 = 2^12 - 100, then +1024 wraps to 924.
        logic [11:0] exp_t;
        for (int b = 0; b < 5; b++) begin
            w_valid = 1'b1; w_last = 1'b0;
            w_bits  = (b < 4) ? 11'd999 : 11'd1024;
            exp_t   = (b < 4) ? 12'(999 * (b + 1)) : 12'd924;
            tick();
            w_valid = 1'b0;
            vectors++;
            if (w_t_out !== exp_t || w_load_v !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_blk%0d: t_out=%0d load_v=%0b, required %0d 1", b, w_t_out, w_load_v, exp_t);
            end
            repeat (34) tick();
            vectors++;
            if (w_busy !== 1'b0 || w_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_idle%0d: busy=%0b ready=%0b, required 0 1", b, w_busy, w_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_two_blocks();
        test_padding_block();
        test_abort();
        test_reset_mid_round();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
